// File: rtl/outlier_drain_filter_if.sv
// Outlier FIFO drain port and surviving-index stream for outlier_drain_filter.
// master = the filter, slave = FIFO/writer side.
interface outlier_drain_filter_if #(
    parameter int N = 16
);
    logic         empty;
    logic [N-1:0] outlier_pos_fifo;
    logic         read_fifo;
    logic         keep_valid;
    logic [N-1:0] keep_idx;
    logic         keep_ready;

    modport master (
        input  empty,
        input  outlier_pos_fifo,
        input  keep_ready,
        output read_fifo,
        output keep_valid,
        output keep_idx
    );

    modport slave (
        output empty,
        output outlier_pos_fifo,
        output keep_ready,
        input  read_fifo,
        input  keep_valid,
        input  keep_idx
    );
endinterface

// File: rtl/outlier_drain_filter.sv
// Drains the outlier-index FIFO into a removal bitmap, then streams
// every index in 0..size-1 that was not marked as an outlier.
module outlier_drain_filter #(
    parameter int N          = 16,
    parameter int MAX_POINTS = 17500
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  done,
    input  logic [N-1:0]          point_cloud_size,
    outlier_drain_filter_if.master bus,
    output logic [N-1:0]          removed_count,
    output logic [N-1:0]          kept_count,
    output logic                  range_error,
    output logic                  filter_done
);
    localparam int AW = $clog2(MAX_POINTS);
    localparam logic [N-1:0] MAXP = N'(MAX_POINTS);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SCAN,
        FINISH
    } state_t;

    state_t                state;
    logic [MAX_POINTS-1:0] bitmap;
    logic [N-1:0]          size;
    logic [N-1:0]          scan_idx;
    logic                  rd_d;
    logic                  keep_valid;
    logic [N-1:0]          keep_idx;
    logic                  rd_req;
    logic [AW-1:0]         pos_a;
    logic [AW-1:0]         scan_a;

    assign rd_req         = (state == DRAIN) & ~bus.empty;
    assign bus.read_fifo  = rd_req;
    assign bus.keep_valid = keep_valid;
    assign bus.keep_idx   = keep_idx;
    // Both addresses are only used after a < size check, so truncation is safe.
    assign pos_a          = AW'(bus.outlier_pos_fifo);
    assign scan_a         = AW'(scan_idx);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            bitmap        <= '0;
            size          <= '0;
            scan_idx      <= '0;
            rd_d          <= 1'b0;
            keep_valid    <= 1'b0;
            keep_idx      <= '0;
            removed_count <= '0;
            kept_count    <= '0;
            range_error   <= 1'b0;
            filter_done   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    rd_d <= 1'b0;
                    if (done) begin
                        size  <= (point_cloud_size > MAXP) ? MAXP
                                                           : point_cloud_size;
                        if (point_cloud_size > MAXP)
                            range_error <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    rd_d <= rd_req;
                    if (rd_d) begin
                        if (bus.outlier_pos_fifo >= size) begin
                            range_error <= 1'b1;
                        end else if (!bitmap[pos_a]) begin
                            bitmap[pos_a] <= 1'b1;
                            removed_count <= removed_count + 1'b1;
                        end
                    end
                    // Leave only once the last popped word has been consumed.
                    if (bus.empty && !rd_d) begin
                        scan_idx <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (keep_valid && bus.keep_ready)
                        kept_count <= kept_count + 1'b1;
                    if (!keep_valid || bus.keep_ready) begin
                        if (scan_idx == size) begin
                            keep_valid  <= 1'b0;
                            filter_done <= 1'b1;
                            state       <= FINISH;
                        end else begin
                            if (!bitmap[scan_a]) begin
                                keep_idx   <= scan_idx;
                                keep_valid <= 1'b1;
                            end else begin
                                keep_valid     <= 1'b0;
                                bitmap[scan_a] <= 1'b0;
                            end
                            scan_idx <= scan_idx + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    keep_valid  <= 1'b0;
                    filter_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/outlier_drain_filter.md
Name: outlier_drain_filter

Overview:
- Consumer-side companion to the outlier-detection Controller.
- After the Controller asserts done, this block drains the Controller's outlier-index FIFO through the read_fifo/empty handshake and marks each drained index in an internal removal bitmap.
- It then scans indices 0..point_cloud_size-1 and emits the index of every point that was not marked, as a valid/ready stream for the downstream point-cloud writer.
- It also reports removed and kept counts and a sticky error flag.

Parameters:
- N, 16, width of point indices, counts and point_cloud_size.
- MAX_POINTS, 17500, bitmap depth; largest supported point_cloud_size.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- done  input  1  Controller done; drain starts on the first cycle it is high in IDLE.
- point_cloud_size  input  N  number of valid points; sampled on the IDLE->DRAIN transition.
- empty  input  1  Controller outlier FIFO empty flag.
- outlier_pos_fifo  input  N  FIFO read data; valid the cycle after a cycle with read_fifo=1.
- read_fifo  output  1  FIFO pop request.
- keep_valid  output  1  keep_idx holds a surviving point index.
- keep_idx  output  N  index of a non-outlier point.
- keep_ready  input  1  downstream accepts keep_idx when keep_valid & keep_ready.
- removed_count  output  N  number of distinct indices marked.
- kept_count  output  N  number of indices accepted downstream.
- range_error  output  1  sticky; set when a drained index is >= the sampled size.
- filter_done  output  1  scan complete; high until reset.

Behaviour:
- Reset values: state=IDLE, read_fifo=0, keep_valid=0, keep_idx=0, removed_count=0, kept_count=0, range_error=0, filter_done=0. All MAX_POINTS bitmap bits are cleared. Reset has priority in every state, including mid-drain and mid-scan, and discards all progress.
- States: IDLE, DRAIN, SCAN, FINISH.
- IDLE:
  - On done=1: latch size=min(point_cloud_size, MAX_POINTS), go to DRAIN.
  - A point_cloud_size above MAX_POINTS also sets range_error.
- DRAIN:
  - read_fifo is combinational and equals (state==DRAIN) & !empty.
  - Registered flag rd_d = previous cycle's read_fifo.
  - When rd_d=1, outlier_pos_fifo is consumed:
    - if the index is < size and its bit is clear: set the bit and increment removed_count;
    - if the bit is already set (duplicate): no count change;
    - if the index is >= size: set range_error and ignore the index.
  - Go to SCAN when empty=1 and rd_d=0. The final word is always consumed before leaving.
  - empty=1 on the first DRAIN cycle means zero outliers: go to SCAN next cycle.
- SCAN:
  - scan_idx starts at 0.
  - Each cycle in which (!keep_valid | keep_ready):
    - if scan_idx < size and its bit is clear: keep_idx<=scan_idx, keep_valid<=1;
    - if scan_idx < size and its bit is set: keep_valid<=0 and clear the bit;
    - in both cases scan_idx increments.
    - if scan_idx == size: keep_valid<=0, go to FINISH.
  - kept_count increments on every keep_valid & keep_ready cycle.
  - keep_idx and keep_valid are held stable while keep_valid & !keep_ready.
  - Latency: the first keep_idx appears 1 cycle after entering SCAN. Throughput is 1 index/cycle with keep_ready tied high.
  - size=0: no keep_valid is emitted; go to FINISH on the first SCAN cycle.
- FINISH:
  - filter_done=1, read_fifo=0, keep_valid=0.
  - Stay in FINISH regardless of done or empty until reset.
- Invariant at FINISH: kept_count + removed_count == size.

Test Plan:
- size=8, FIFO holds {2,5}, keep_ready=1: read_fifo is high for 2 cycles; keep_idx stream is 0,1,3,4,6,7; removed_count=2, kept_count=6, filter_done=1.
- size=4, FIFO holds {1,1,3}: duplicate ignored; stream is 0,2; removed_count=2, kept_count=2, range_error=0.
- size=4, FIFO holds {9}: range_error=1, removed_count=0; stream is 0,1,2,3.
- size=6, empty FIFO, keep_ready toggling 1,0,0,1,...: keep_idx is held during stall cycles; each of 0..5 is delivered exactly once; kept_count=6.
- size=8, FIFO {0,7}: assert reset in the middle of SCAN, then re-run with FIFO {3}: all counters and flags return to 0; the second run streams the 7 indices other than 3 and removed_count=1.
- size=0, FIFO empty, done=1: filter_done=1 within 3 cycles; no keep_valid is ever asserted.
